turn_sequencer: RTL and testbench
=================================

TURN_SEQUENCER -- requirements
Module: turn_sequencer

Interface
REQ-001 SHALL have parameter AI_WAIT, default 1, the number of cycles between presenting the boards and sampling ai_move (range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: a 1-cycle pulse that begins a new game; it is honoured only in IDLE or DONE.
REQ-005 SHALL have port move_valid, input, 1 bit: the human (O) move strobe.
REQ-006 SHALL have port move_idx, input, 4 bits: the human cell index, 8 = top-left ... 0 = bottom-right, row-major.
REQ-007 SHALL have port ai_move, input, 9 bits: the one-hot AI (X) cell from the combinational lookup; 0 means no suggestion.
REQ-008 SHALL have port x_state, output, 9 bits: the registered X board, bit 8 = top-left.
REQ-009 SHALL have port o_state, output, 9 bits: the registered O board, with the same mapping as x_state.
REQ-010 SHALL have port move_ready, output, 1 bit: high only in WAIT_O.
REQ-011 SHALL have port illegal, output, 1 bit: a 1-cycle pulse on a rejected human move.
REQ-012 SHALL have port game_over, output, 1 bit: high in DONE.
REQ-013 SHALL have port winner, output, 2 bits: 00 none/draw, 01 X, 10 O; valid while game_over is high.
REQ-014 SHALL have port move_count, output, 4 bits: the number of occupied cells, 0..9.

Function
REQ-015 SHALL implement the states IDLE, AI_REQ, AI_COMMIT, CHECK_X, WAIT_O, CHECK_O and DONE.
REQ-016 SHALL, on start in IDLE or DONE, clear x_state, o_state, winner and move_count, and enter AI_REQ.
REQ-017 SHALL, in AI_REQ, hold the boards stable for AI_WAIT cycles using a down-counter, then enter AI_COMMIT.
REQ-018 SHALL, in AI_COMMIT, accept ai_move only if it is exactly one-hot and its bit is empty in (x_state|o_state).
REQ-019 SHALL, when ai_move is not accepted in AI_COMMIT, instead place X on the highest-index empty cell.
REQ-020 SHALL increment move_count by one in AI_COMMIT and proceed to CHECK_X.
REQ-021 SHALL, in CHECK_X, go to DONE with winner=01 if x_state holds any of the 8 lines (3 rows, 3 columns, 2 diagonals); else to DONE with winner=00 if move_count==9; else to WAIT_O.
REQ-022 SHALL, in WAIT_O with move_valid high, reject the move when move_idx>8 or the target cell is occupied: pulse illegal the next cycle, leave the boards unchanged and remain in WAIT_O.
REQ-023 SHALL, in WAIT_O with a legal move, set o_state[move_idx], increment move_count and enter CHECK_O.
REQ-024 SHALL, in CHECK_O, go to DONE with winner=10 on an O line; else to DONE with winner=00 if move_count==9; else to AI_REQ.
REQ-025 SHALL ignore move_valid in every state other than WAIT_O, without pulsing illegal.
REQ-026 SHALL ignore start in every state other than IDLE and DONE.
REQ-027 SHALL hold the boards and winner in DONE until start.
REQ-028 SHALL, when both start and move_valid are high in DONE, let start win.
REQ-029 SHALL guarantee that x_state&o_state is always zero.
REQ-030 SHALL make every output a registered value or a pure decode of the state register.
REQ-031 SHALL place the first X move in the cycle 1+AI_WAIT+1 after start; with AI_WAIT=1, x_state is updated at the third rising edge after start.

Reset
REQ-032 SHALL, while rst is high, force IDLE with x_state=0, o_state=0, move_count=0, winner=00, illegal=0, game_over=0, move_ready=0, and the wait counter at 0.
REQ-033 SHALL, when rst is asserted mid-game (any state), abandon the game immediately with no further board writes.
REQ-034 SHALL leave IDLE after reset release only on start.

Structure
REQ-035 SHALL take the state encoding, the WINNER_* codes, the 8 win-line masks and the CELL_TL..CELL_BR constants from a shared package, tictactoe_pkg.
REQ-036 SHALL implement line detection as the sub-module win_detect (9-bit board in, 1-bit win out), instantiated once for X and once for O.
REQ-037 SHALL NOT instantiate the lookup table; ai_move arrives on a port.

Verification
REQ-038 SHALL be tested: rst, start, ai_move=100000000 -> x_state=100000000, move_count=1, move_ready=1.
REQ-039 SHALL be tested: in WAIT_O with x_state=100000000, move_idx=8 -> illegal pulse, boards unchanged; then move_idx=4 -> o_state=000010000, move_count=2.
REQ-040 SHALL be tested: x_state=101000000 and ai_move=010000000 -> x_state=111000000, game_over=1, winner=01.
REQ-041 SHALL be tested: ai_move=000000000 on the empty board -> X on cell 8; ai_move=110000000 -> fallback to the highest-index empty cell.
REQ-042 SHALL be tested: a scripted full draw (9 moves, no line) -> move_count=9, game_over=1, winner=00.
REQ-043 SHALL be tested: rst asserted in AI_REQ -> all outputs return to zero asynchronously; start afterwards replays the REQ-038 sequence identically.

Source files
------------

// File: rtl/tictactoe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tictactoe_pkg
// Purpose  : Shared definitions for the tic-tac-toe turn sequencer: FSM state
//            encoding, winner codes, cell indices, the eight win-line masks
//            and small board helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tictactoe_pkg;

  // Board bit 8 is the top-left cell, bit 0 the bottom-right (row-major).
  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    AI_REQ    = 3'd1,
    AI_COMMIT = 3'd2,
    CHECK_X   = 3'd3,
    WAIT_O    = 3'd4,
    CHECK_O   = 3'd5,
    DONE      = 3'd6
  } state_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_X    = 2'b01;
  localparam logic [1:0] WINNER_O    = 2'b10;

  localparam logic [3:0] CELL_TL = 4'd8;
  localparam logic [3:0] CELL_TM = 4'd7;
  localparam logic [3:0] CELL_TR = 4'd6;
  localparam logic [3:0] CELL_ML = 4'd5;
  localparam logic [3:0] CELL_C  = 4'd4;
  localparam logic [3:0] CELL_MR = 4'd3;
  localparam logic [3:0] CELL_BL = 4'd2;
  localparam logic [3:0] CELL_BM = 4'd1;
  localparam logic [3:0] CELL_BR = 4'd0;

  // Three rows, three columns, two diagonals.
  localparam logic [NUM_LINES-1:0][NUM_CELLS-1:0] WIN_LINES = {
    9'b111_000_000,
    9'b000_111_000,
    9'b000_000_111,
    9'b100_100_100,
    9'b010_010_010,
    9'b001_001_001,
    9'b100_010_001,
    9'b001_010_100
  };

  // One-hot of the highest-index empty cell; zero when the board is full.
  // Ascending scan so the last (highest) empty cell found wins.
  function automatic logic [NUM_CELLS-1:0] highest_empty(input logic [NUM_CELLS-1:0] occ);
    highest_empty = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (!occ[i]) highest_empty = 9'b1 << i;
    end
  endfunction

  function automatic logic is_one_hot(input logic [NUM_CELLS-1:0] v);
    is_one_hot = (v != '0) && ((v & (v - 9'd1)) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/win_detect.sv
`default_nettype none
// ============================================================================
// Module   : win_detect
// Purpose  : Flags whether a single player's board holds any complete line.
// Ports    : board - 9-bit occupancy of one player (bit 8 = top-left)
//            win   - high when any row, column or diagonal is fully set
// Revision : 1.0 - initial release
// ============================================================================
module win_detect
  import tictactoe_pkg::*;
(
  input  logic [NUM_CELLS-1:0] board,
  output logic                 win
);

  logic [NUM_LINES-1:0] w_hit;

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    assign w_hit[g] = ((board & WIN_LINES[g]) == WIN_LINES[g]);
  end

  assign win = |w_hit;

endmodule
`default_nettype wire

// File: rtl/turn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : turn_sequencer
// Purpose  : Alternates X (external AI lookup) and O (human) turns on a 3x3
//            board, rejecting illegal human moves and detecting win/draw.
// Ports    : clk, rst    - clock, asynchronous active-high reset
//            start       - pulse, begins a game from IDLE or DONE
//            move_valid  - human move strobe, move_idx = cell (8 = TL)
//            ai_move     - one-hot suggested X cell, 0 = no suggestion
//            x_state     - registered X board
//            o_state     - registered O board
//            move_ready  - waiting for the human move
//            illegal     - 1-cycle pulse after a rejected human move
//            game_over   - game finished, winner valid
//            winner      - 00 none/draw, 01 X, 10 O
//            move_count  - occupied cells 0..9
// Revision : 1.0 - initial release
// ============================================================================
module turn_sequencer
  import tictactoe_pkg::*;
#(
  parameter int AI_WAIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 move_valid,
  input  logic [3:0]           move_idx,
  input  logic [NUM_CELLS-1:0] ai_move,
  output logic [NUM_CELLS-1:0] x_state,
  output logic [NUM_CELLS-1:0] o_state,
  output logic                 move_ready,
  output logic                 illegal,
  output logic                 game_over,
  output logic [1:0]           winner,
  output logic [3:0]           move_count
);

  localparam logic [3:0] c_ai_wait   = 4'(AI_WAIT);
  localparam logic [3:0] c_full_cnt  = 4'(NUM_CELLS);

  state_t               r_state, w_state_nxt;
  logic [NUM_CELLS-1:0] r_x, w_x_nxt;
  logic [NUM_CELLS-1:0] r_o, w_o_nxt;
  logic [3:0]           r_count, w_count_nxt;
  logic [1:0]           r_winner, w_winner_nxt;
  logic                 r_illegal, w_illegal_nxt;
  logic [3:0]           r_wait_cnt, w_wait_nxt;

  logic [NUM_CELLS-1:0] w_occ;
  logic                 w_ai_ok;
  logic [NUM_CELLS-1:0] w_o_bit;
  logic                 w_o_legal;
  logic                 w_x_win;
  logic                 w_o_win;

  win_detect u_win_x (.board(r_x), .win(w_x_win));
  win_detect u_win_o (.board(r_o), .win(w_o_win));

  assign w_occ   = r_x | r_o;
  assign w_ai_ok = is_one_hot(ai_move) && ((ai_move & w_occ) == '0);
  // Out-of-range indices decode to no cell so they can never touch the board.
  assign w_o_bit   = (move_idx <= CELL_TL) ? (9'b1 << move_idx) : '0;
  assign w_o_legal = (w_o_bit != '0) && ((w_o_bit & w_occ) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_x_nxt       = r_x;
    w_o_nxt       = r_o;
    w_count_nxt   = r_count;
    w_winner_nxt  = r_winner;
    w_illegal_nxt = 1'b0;
    w_wait_nxt    = r_wait_cnt;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_x_nxt      = '0;
          w_o_nxt      = '0;
          w_count_nxt  = '0;
          w_winner_nxt = WINNER_NONE;
          w_wait_nxt   = c_ai_wait;
          w_state_nxt  = AI_REQ;
        end
      end
      AI_REQ: begin
        // Boards are frozen here so the external lookup sees a stable input.
        if (r_wait_cnt <= 4'd1) begin
          w_wait_nxt  = '0;
          w_state_nxt = AI_COMMIT;
        end else begin
          w_wait_nxt  = r_wait_cnt - 4'd1;
        end
      end
      AI_COMMIT: begin
        w_x_nxt     = r_x | (w_ai_ok ? ai_move : highest_empty(w_occ));
        w_count_nxt = r_count + 4'd1;
        w_state_nxt = CHECK_X;
      end
      CHECK_X: begin
        if (w_x_win) begin
          w_winner_nxt = WINNER_X;
          w_state_nxt  = DONE;
        end else if (r_count == c_full_cnt) begin
          w_winner_nxt = WINNER_NONE;
          w_state_nxt  = DONE;
        end else begin
          w_state_nxt  = WAIT_O;
        end
      end
      WAIT_O: begin
        if (move_valid) begin
          if (w_o_legal) begin
            w_o_nxt     = r_o | w_o_bit;
            w_count_nxt = r_count + 4'd1;
            w_state_nxt = CHECK_O;
          end else begin
            w_illegal_nxt = 1'b1;
          end
        end
      end
      CHECK_O: begin
        if (w_o_win) begin
          w_winner_nxt = WINNER_O;
          w_state_nxt  = DONE;
        end else if (r_count == c_full_cnt) begin
          w_winner_nxt = WINNER_NONE;
          w_state_nxt  = DONE;
        end else begin
          w_wait_nxt   = c_ai_wait;
          w_state_nxt  = AI_REQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x        <= '0;
      r_o        <= '0;
      r_count    <= '0;
      r_winner   <= WINNER_NONE;
      r_illegal  <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_x        <= w_x_nxt;
      r_o        <= w_o_nxt;
      r_count    <= w_count_nxt;
      r_winner   <= w_winner_nxt;
      r_illegal  <= w_illegal_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  assign x_state    = r_x;
  assign o_state    = r_o;
  assign move_count = r_count;
  assign winner     = r_winner;
  assign illegal    = r_illegal;
  assign move_ready = (r_state == WAIT_O);
  assign game_over  = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_turn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_turn_sequencer
// Purpose  : Directed self-checking bench for turn_sequencer (AI_WAIT = 1).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_turn_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       move_valid = 1'b0;
  logic [3:0] move_idx = 4'd0;
  logic [8:0] ai_move = 9'd0;
  logic [8:0] x_state, o_state;
  logic       move_ready, illegal, game_over;
  logic [1:0] winner;
  logic [3:0] move_count;

  int n_cmp = 0;
  int n_bad = 0;

  turn_sequencer #(.AI_WAIT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .move_valid(move_valid),
    .move_idx(move_idx), .ai_move(ai_move), .x_state(x_state),
    .o_state(o_state), .move_ready(move_ready), .illegal(illegal),
    .game_over(game_over), .winner(winner), .move_count(move_count)
  );

  always #5 clk = ~clk;

  // Stimulus helpers (inputs change on the falling edge).
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic o_move(input logic [3:0] idx);
    @(negedge clk) begin move_valid = 1'b1; move_idx = idx; end
    @(negedge clk) move_valid = 1'b0;
  endtask

  // Wait until the human is asked to move or the game ends.
  task automatic wait_turn(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (move_ready || game_over) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if ({x_state, o_state, move_count, winner, illegal, game_over, move_ready} !== 30'd0) begin
      n_bad++; $display("FAIL reset_outputs: got x=%b o=%b cnt=%0d w=%b ill=%b go=%b rdy=%b want all 0",
                        x_state, o_state, move_count, winner, illegal, game_over, move_ready);
    end
    rst = 1'b0;
    move_valid = 1'b1; move_idx = 4'd3;
    repeat (3) @(negedge clk);
    move_valid = 1'b0;
    n_cmp++;
    if ({x_state, o_state, move_count, illegal, game_over, move_ready} !== 28'd0) begin
      n_bad++; $display("FAIL idle_ignores_move: got x=%b o=%b cnt=%0d ill=%b go=%b rdy=%b want all 0",
                        x_state, o_state, move_count, illegal, game_over, move_ready);
    end
  endtask

  // Start + first X move, including exact latency (X lands on 3rd edge).
  task automatic test_first_move(input string tag);
    ai_move = 9'b100000000;
    pulse_start();
    n_cmp++;
    if (x_state !== 9'd0) begin n_bad++; $display("FAIL %s_edge1: got x=%b want 0", tag, x_state); end
    @(negedge clk);
    n_cmp++;
    if (x_state !== 9'd0) begin n_bad++; $display("FAIL %s_edge2: got x=%b want 0", tag, x_state); end
    @(negedge clk);
    n_cmp++;
    if ({x_state, o_state, move_count} !== {9'b100000000, 9'd0, 4'd1}) begin
      n_bad++; $display("FAIL %s_edge3: got x=%b o=%b cnt=%0d want x=100000000 o=0 cnt=1", tag, x_state, o_state, move_count);
    end
    @(negedge clk);
    n_cmp++;
    if ({move_ready, game_over} !== 2'b10) begin
      n_bad++; $display("FAIL %s_ready: got rdy=%b go=%b want rdy=1 go=0", tag, move_ready, game_over);
    end
  endtask

  task automatic test_illegal();
    bit seen_ill;
    bit ok;
    o_move(4'd8);
    n_cmp++;
    if ({illegal, x_state, o_state, move_ready} !== {1'b1, 9'b100000000, 9'd0, 1'b1}) begin
      n_bad++; $display("FAIL illegal_occupied: got ill=%b x=%b o=%b rdy=%b want ill=1 x=100000000 o=0 rdy=1", illegal, x_state, o_state, move_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (illegal !== 1'b0) begin n_bad++; $display("FAIL illegal_one_cycle: got %b want 0", illegal); end
    o_move(4'd9);
    n_cmp++;
    if ({illegal, o_state, move_count} !== {1'b1, 9'd0, 4'd1}) begin
      n_bad++; $display("FAIL illegal_range: got ill=%b o=%b cnt=%0d want ill=1 o=0 cnt=1", illegal, o_state, move_count);
    end
    o_move(4'd4);
    n_cmp++;
    if ({o_state, move_count, illegal, move_ready} !== {9'b000010000, 4'd2, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL legal_o: got o=%b cnt=%0d ill=%b rdy=%b want o=000010000 cnt=2 ill=0 rdy=0", o_state, move_count, illegal, move_ready);
    end
    // Now in CHECK_O: move_valid and start must both be ignored here and in AI_REQ.
    move_valid = 1'b1; move_idx = 4'd5; start = 1'b1; ai_move = 9'b001000000;
    seen_ill = 1'b0;
    @(negedge clk); seen_ill |= illegal;
    @(negedge clk); seen_ill |= illegal;
    move_valid = 1'b0; start = 1'b0;
    n_cmp++;
    if ({seen_ill, o_state, move_count} !== {1'b0, 9'b000010000, 4'd2}) begin
      n_bad++; $display("FAIL ignore_outside_wait: got ill=%b o=%b cnt=%0d want ill=0 o=000010000 cnt=2", seen_ill, o_state, move_count);
    end
    wait_turn(20, ok);
    n_cmp++;
    if ({ok, x_state, move_count, move_ready} !== {1'b1, 9'b101000000, 4'd3, 1'b1}) begin
      n_bad++; $display("FAIL second_x: got ok=%b x=%b cnt=%0d rdy=%b want ok=1 x=101000000 cnt=3 rdy=1", ok, x_state, move_count, move_ready);
    end
  endtask

  task automatic test_x_win();
    bit ok;
    bit seen_ill;
    o_move(4'd0);
    ai_move = 9'b010000000;
    wait_turn(20, ok);
    n_cmp++;
    if ({ok, x_state, o_state, move_count, game_over, winner, move_ready} !==
        {1'b1, 9'b111000000, 9'b000010001, 4'd5, 1'b1, 2'b01, 1'b0}) begin
      n_bad++; $display("FAIL x_win: got ok=%b x=%b o=%b cnt=%0d go=%b w=%b rdy=%b want x=111000000 o=000010001 cnt=5 go=1 w=01 rdy=0",
                        ok, x_state, o_state, move_count, game_over, winner, move_ready);
    end
    move_valid = 1'b1; move_idx = 4'd3; seen_ill = 1'b0;
    repeat (3) begin @(negedge clk); seen_ill |= illegal; end
    move_valid = 1'b0;
    n_cmp++;
    if ({seen_ill, x_state, o_state, game_over, winner} !== {1'b0, 9'b111000000, 9'b000010001, 1'b1, 2'b01}) begin
      n_bad++; $display("FAIL done_hold: got ill=%b x=%b o=%b go=%b w=%b want ill=0 x=111000000 o=000010001 go=1 w=01",
                        seen_ill, x_state, o_state, game_over, winner);
    end
  endtask

  task automatic test_fallback();
    bit ok;
    ai_move = 9'd0;
    pulse_start();
    wait_turn(20, ok);
    n_cmp++;
    if ({ok, x_state, o_state, move_count, winner} !== {1'b1, 9'b100000000, 9'd0, 4'd1, 2'b00}) begin
      n_bad++; $display("FAIL fallback_zero: got ok=%b x=%b o=%b cnt=%0d w=%b want x=100000000 o=0 cnt=1 w=00", ok, x_state, o_state, move_count, winner);
    end
    o_move(4'd4);
    ai_move = 9'b110000000;
    wait_turn(20, ok);
    n_cmp++;
    if ({ok, x_state, move_count} !== {1'b1, 9'b110000000, 4'd3}) begin
      n_bad++; $display("FAIL fallback_multi: got ok=%b x=%b cnt=%0d want x=110000000 cnt=3", ok, x_state, move_count);
    end
    o_move(4'd0);
    ai_move = 9'b000010000;
    wait_turn(20, ok);
    n_cmp++;
    if ({ok, x_state, move_count, game_over, winner} !== {1'b1, 9'b111000000, 4'd5, 1'b1, 2'b01}) begin
      n_bad++; $display("FAIL fallback_occupied: got ok=%b x=%b cnt=%0d go=%b w=%b want x=111000000 cnt=5 go=1 w=01",
                        ok, x_state, move_count, game_over, winner);
    end
  endtask

  task automatic test_draw();
    logic [3:0] xs [5];
    logic [3:0] os [4];
    logic [8:0] one;
    bit ok;
    xs = '{4'd8, 4'd6, 4'd1, 4'd5, 4'd0};
    os = '{4'd4, 4'd7, 4'd3, 4'd2};
    one = 9'd1;
    ai_move = one << xs[0];
    // start and move_valid together in DONE: start wins.
    @(negedge clk) begin start = 1'b1; move_valid = 1'b1; move_idx = 4'd3; end
    @(negedge clk) begin start = 1'b0; move_valid = 1'b0; end
    n_cmp++;
    if ({x_state, o_state, move_count, winner, game_over, illegal} !== 24'd0) begin
      n_bad++; $display("FAIL start_wins: got x=%b o=%b cnt=%0d w=%b go=%b ill=%b want all 0",
                        x_state, o_state, move_count, winner, game_over, illegal);
    end
    for (int k = 0; k < 5; k++) begin
      ai_move = one << xs[k];
      wait_turn(20, ok);
      n_cmp++;
      if (ok !== 1'b1) begin n_bad++; $display("FAIL draw_turn%0d: got timeout want move_ready/game_over", k); end
      if (k < 4) o_move(os[k]);
    end
    n_cmp++;
    if ({x_state, o_state, move_count, game_over, winner} !==
        {9'b101100011, 9'b010011100, 4'd9, 1'b1, 2'b00}) begin
      n_bad++; $display("FAIL draw_final: got x=%b o=%b cnt=%0d go=%b w=%b want x=101100011 o=010011100 cnt=9 go=1 w=00",
                        x_state, o_state, move_count, game_over, winner);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    ai_move = 9'b100000000;
    pulse_start();
    wait_turn(20, ok);
    o_move(4'd4);
    @(negedge clk);   // CHECK_O -> AI_REQ
    n_cmp++;
    if ({ok, move_count, o_state, move_ready, game_over} !== {1'b1, 4'd2, 9'b000010000, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL pre_reset: got ok=%b cnt=%0d o=%b rdy=%b go=%b want ok=1 cnt=2 o=000010000 rdy=0 go=0",
                        ok, move_count, o_state, move_ready, game_over);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({x_state, o_state, move_count, winner, illegal, game_over, move_ready} !== 30'd0) begin
      n_bad++; $display("FAIL async_reset: got x=%b o=%b cnt=%0d w=%b ill=%b go=%b rdy=%b want all 0",
                        x_state, o_state, move_count, winner, illegal, game_over, move_ready);
    end
    @(negedge clk);
    n_cmp++;
    if ({x_state, o_state, move_count, move_ready} !== 23'd0) begin
      n_bad++; $display("FAIL reset_hold: got x=%b o=%b cnt=%0d rdy=%b want all 0", x_state, o_state, move_count, move_ready);
    end
    rst = 1'b0;
    test_first_move("replay");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_move("first");
    test_illegal();
    test_x_win();
    test_fallback();
    test_draw();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
